// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types for the pipeline hazard controller
package pipeline_pkg;

    localparam int REG_AW = 5;

    typedef struct packed {
        logic              wr;
        logic [REG_AW-1:0] rd;
        logic              ld;
    } hist_entry_t;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_P1 = 2'd1,
        FWD_P2 = 2'd2,
        FWD_P3 = 2'd3
    } fwd_sel_t;

    // x0 is never a real destination, so it is recorded as "no write".
    function automatic hist_entry_t make_entry(input logic wr, input logic [REG_AW-1:0] rd,
                                               input logic ld);
        hist_entry_t e;
        e.wr = wr && (rd != '0);
        e.rd = rd;
        e.ld = ld;
        return e;
    endfunction

endpackage

// File: rtl/fwd_select.sv
// rtl/fwd_select.sv - per-source priority match against the EX/MEM/WB history
module fwd_select
    import pipeline_pkg::*;
(
    input  logic              src_use,
    input  logic [REG_AW-1:0] src_addr,
    input  hist_entry_t       h1,
    input  hist_entry_t       h2,
    input  hist_entry_t       h3,
    output fwd_sel_t          fwd,
    output logic              take_mem,
    output logic              load_use_hit
);

    logic live;
    logic m1, m2, m3;

    assign live = src_use && (src_addr != '0);
    assign m1   = live && h1.wr && (h1.rd == src_addr);
    assign m2   = live && h2.wr && (h2.rd == src_addr);
    assign m3   = live && h3.wr && (h3.rd == src_addr);

    // Nearest producer wins: the youngest entry holds the newest value.
    always_comb begin
        fwd      = FWD_RF;
        take_mem = 1'b0;
        if (m1) begin
            fwd      = FWD_P1;
            take_mem = h1.ld;
        end else if (m2) begin
            fwd      = FWD_P2;
            take_mem = h2.ld;
        end else if (m3) begin
            fwd      = FWD_P3;
            take_mem = h3.ld;
        end
    end

    assign load_use_hit = m1 && h1.ld;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - forwarding selects, load-use bubbles, redirect flush and memory freeze
module hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic              id_rd_write,
    input  logic              id_is_load,
    input  logic              ex_redirect,
    input  logic              mem_busy,
    output logic [1:0]        rs1_fwd,
    output logic [1:0]        rs2_fwd,
    output logic              rs1_take_mem,
    output logic              rs2_take_mem,
    output logic              id_stall,
    output logic              ex_bubble,
    output logic              flush_if_id,
    output logic              pipe_freeze,
    output logic [CNT_W-1:0]  bubble_count
);

    import pipeline_pkg::*;

    hist_entry_t      h1_q, h2_q, h3_q;
    logic [CNT_W-1:0] cnt_q;
    fwd_sel_t         rs1_sel, rs2_sel;
    logic             rs1_tm, rs2_tm;
    logic             rs1_lu, rs2_lu;
    logic             load_use;
    logic             advance;

    fwd_select u_rs1 (
        .src_use      (id_use_rs1),
        .src_addr     (id_rs1_addr),
        .h1           (h1_q),
        .h2           (h2_q),
        .h3           (h3_q),
        .fwd          (rs1_sel),
        .take_mem     (rs1_tm),
        .load_use_hit (rs1_lu)
    );

    fwd_select u_rs2 (
        .src_use      (id_use_rs2),
        .src_addr     (id_rs2_addr),
        .h1           (h1_q),
        .h2           (h2_q),
        .h3           (h3_q),
        .fwd          (rs2_sel),
        .take_mem     (rs2_tm),
        .load_use_hit (rs2_lu)
    );

    assign load_use = id_valid && (rs1_lu || rs2_lu);
    assign advance  = !reset && !mem_busy;

    // A redirect squashes decode, so it takes precedence over a load-use stall.
    assign pipe_freeze  = !reset && mem_busy;
    assign flush_if_id  = advance && ex_redirect;
    assign ex_bubble    = advance && (ex_redirect || load_use);
    assign id_stall     = advance && !ex_redirect && load_use;

    assign rs1_fwd      = reset ? 2'd0 : rs1_sel;
    assign rs2_fwd      = reset ? 2'd0 : rs2_sel;
    assign rs1_take_mem = !reset && rs1_tm;
    assign rs2_take_mem = !reset && rs2_tm;
    assign bubble_count = reset ? '0 : cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            h1_q  <= '0;
            h2_q  <= '0;
            h3_q  <= '0;
            cnt_q <= '0;
        end else if (!mem_busy) begin
            h3_q <= h2_q;
            h2_q <= h1_q;
            h1_q <= (id_valid && !ex_bubble) ?
                    make_entry(id_rd_write, id_rd_addr, id_is_load) : '0;
            if (ex_bubble && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed bench with a queue-based model of the hazard controller
module tb_hazard_ctrl;

    localparam int AW   = 5;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          id_valid;
    logic [AW-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic          id_use_rs1, id_use_rs2, id_rd_write, id_is_load;
    logic          ex_redirect, mem_busy;
    logic [1:0]    rs1_fwd, rs2_fwd;
    logic          rs1_take_mem, rs2_take_mem;
    logic          id_stall, ex_bubble, flush_if_id, pipe_freeze;
    logic [CW-1:0] bubble_count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rs1_addr  (id_rs1_addr),
        .id_rs2_addr  (id_rs2_addr),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_rd_addr   (id_rd_addr),
        .id_rd_write  (id_rd_write),
        .id_is_load   (id_is_load),
        .ex_redirect  (ex_redirect),
        .mem_busy     (mem_busy),
        .rs1_fwd      (rs1_fwd),
        .rs2_fwd      (rs2_fwd),
        .rs1_take_mem (rs1_take_mem),
        .rs2_take_mem (rs2_take_mem),
        .id_stall     (id_stall),
        .ex_bubble    (ex_bubble),
        .flush_if_id  (flush_if_id),
        .pipe_freeze  (pipe_freeze),
        .bubble_count (bubble_count)
    );

    always #5 clk = ~clk;

    // Model: the last three issued slots, newest first; bubbles occupy a slot too.
    typedef struct {
        bit wr;
        int rd;
        bit ld;
    } mrec_t;

    mrec_t hist[$];
    int    mcnt = 0;

    function automatic void src_model(input bit u, input int a,
                                      output int f, output bit tm, output bit lu);
        f = 0; tm = 0; lu = 0;
        if (u && a != 0) begin
            for (int k = 0; k < hist.size(); k++) begin
                if (hist[k].wr && hist[k].rd == a) begin
                    f  = k + 1;
                    tm = hist[k].ld;
                    lu = (k == 0) && hist[k].ld;
                    break;
                end
            end
        end
    endfunction

    function automatic void model(output int f1, output int f2, output bit t1, output bit t2,
                                  output bit stall, output bit bub, output bit flush,
                                  output bit frz, output int cnt);
        bit lu1, lu2, hazard;
        src_model(id_use_rs1, int'(id_rs1_addr), f1, t1, lu1);
        src_model(id_use_rs2, int'(id_rs2_addr), f2, t2, lu2);
        hazard = id_valid && (lu1 || lu2);
        frz    = mem_busy;
        flush  = !mem_busy && ex_redirect;
        bub    = !mem_busy && (ex_redirect || hazard);
        stall  = !mem_busy && !ex_redirect && hazard;
        cnt    = mcnt;
        if (reset) begin
            f1 = 0; f2 = 0; t1 = 0; t2 = 0;
            stall = 0; bub = 0; flush = 0; frz = 0; cnt = 0;
        end
    endfunction

    always @(posedge clk) begin
        int f1, f2, cnt;
        bit t1, t2, stall, bub, flush, frz;
        mrec_t r;
        model(f1, f2, t1, t2, stall, bub, flush, frz, cnt);
        if (reset) begin
            hist.delete();
            mcnt = 0;
        end else if (!mem_busy) begin
            if (bub && mcnt < CMAX) mcnt++;
            r.wr = 0; r.rd = 0; r.ld = 0;
            if (id_valid && !bub) begin
                r.wr = id_rd_write && (id_rd_addr != 0);
                r.rd = int'(id_rd_addr);
                r.ld = id_is_load;
            end
            hist.push_front(r);
            if (hist.size() > 3) void'(hist.pop_back());
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        int f1, f2, cnt;
        bit t1, t2, stall, bub, flush, frz;
        model(f1, f2, t1, t2, stall, bub, flush, frz, cnt);
        chk("model rs1_fwd", int'(rs1_fwd), f1);
        chk("model rs2_fwd", int'(rs2_fwd), f2);
        chk("model rs1_take_mem", int'(rs1_take_mem), int'(t1));
        chk("model rs2_take_mem", int'(rs2_take_mem), int'(t2));
        chk("model id_stall", int'(id_stall), int'(stall));
        chk("model ex_bubble", int'(ex_bubble), int'(bub));
        chk("model flush_if_id", int'(flush_if_id), int'(flush));
        chk("model pipe_freeze", int'(pipe_freeze), int'(frz));
        chk("model bubble_count", int'(bubble_count), cnt);
    end

    // Drive one decode slot after the rising edge, then settle past the falling edge.
    task automatic step(input bit rst, input bit v, input int r1, input bit u1,
                        input int r2, input bit u2, input int rd, input bit wr, input bit ld,
                        input bit redir, input bit busy);
        @(posedge clk);
        #1;
        reset       = rst;
        id_valid    = v;
        id_rs1_addr = AW'(r1);
        id_use_rs1  = u1;
        id_rs2_addr = AW'(r2);
        id_use_rs2  = u2;
        id_rd_addr  = AW'(rd);
        id_rd_write = wr;
        id_is_load  = ld;
        ex_redirect = redir;
        mem_busy    = busy;
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1; id_valid = 1; id_rs1_addr = 3; id_use_rs1 = 1; id_rs2_addr = 0;
        id_use_rs2 = 0; id_rd_addr = 0; id_rd_write = 0; id_is_load = 0;
        ex_redirect = 0; mem_busy = 1;
        @(negedge clk);
        #1;
        chk("reset beats busy pipe_freeze", int'(pipe_freeze), 0);
        chk("reset rs1_fwd", int'(rs1_fwd), 0);

        // load-use: lw x5 ; add x6,x5,x1 (stalled once)
        step(0, 1, 1, 1, 0, 0, 5, 1, 1, 0, 0);
        chk("lw id_stall", int'(id_stall), 0);
        step(0, 1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
        chk("lu id_stall", int'(id_stall), 1);
        chk("lu ex_bubble", int'(ex_bubble), 1);
        chk("lu rs1_fwd", int'(rs1_fwd), 1);
        step(0, 1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
        chk("lu retry rs1_fwd", int'(rs1_fwd), 2);
        chk("lu retry rs1_take_mem", int'(rs1_take_mem), 1);
        chk("lu retry id_stall", int'(id_stall), 0);
        chk("lu bubble_count", int'(bubble_count), 1);

        // ALU chain: add x3 ; sub x3 ; or x7,x3,x3
        step(0, 1, 1, 1, 2, 1, 3, 1, 0, 0, 0);
        step(0, 1, 1, 1, 2, 1, 3, 1, 0, 0, 0);
        step(0, 1, 3, 1, 3, 1, 7, 1, 0, 0, 0);
        chk("chain rs1_fwd", int'(rs1_fwd), 1);
        chk("chain rs2_fwd", int'(rs2_fwd), 1);
        chk("chain rs1_take_mem", int'(rs1_take_mem), 0);
        chk("chain id_stall", int'(id_stall), 0);

        // x0: addi x0,x0,1 ; add x2,x0,x0
        step(0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 0, 1, 2, 1, 0, 0, 0);
        chk("x0 rs1_fwd", int'(rs1_fwd), 0);
        chk("x0 rs2_fwd", int'(rs2_fwd), 0);
        chk("x0 id_stall", int'(id_stall), 0);

        // redirect coinciding with a load-use match
        step(0, 1, 1, 1, 0, 0, 8, 1, 1, 0, 0);
        step(0, 1, 8, 1, 0, 1, 9, 1, 0, 1, 0);
        chk("redir flush_if_id", int'(flush_if_id), 1);
        chk("redir ex_bubble", int'(ex_bubble), 1);
        chk("redir id_stall", int'(id_stall), 0);
        step(0, 1, 8, 1, 0, 1, 9, 1, 0, 0, 0);
        chk("post redir rs1_fwd", int'(rs1_fwd), 2);
        chk("post redir bubble_count", int'(bubble_count), 2);

        // mem_busy with x4 in h2
        step(0, 1, 1, 1, 0, 0, 4, 1, 0, 0, 0);
        step(0, 1, 1, 1, 0, 0, 10, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 4, 1, 0, 0, 11, 1, 0, 0, 1);
            chk("busy pipe_freeze", int'(pipe_freeze), 1);
            chk("busy rs1_fwd", int'(rs1_fwd), 2);
            chk("busy id_stall", int'(id_stall), 0);
        end
        step(0, 1, 4, 1, 0, 0, 11, 1, 0, 0, 0);
        chk("release rs1_fwd", int'(rs1_fwd), 2);
        step(0, 1, 4, 1, 0, 0, 11, 1, 0, 0, 0);
        chk("release+1 rs1_fwd", int'(rs1_fwd), 3);
        step(0, 1, 4, 1, 0, 0, 11, 1, 0, 0, 0);
        chk("release+2 rs1_fwd", int'(rs1_fwd), 0);

        // bubble counter saturation
        for (int i = 0; i < 16; i++) step(0, 1, 1, 1, 0, 0, 12, 1, 0, 1, 0);
        step(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("saturated bubble_count", int'(bubble_count), CMAX);

        // reset mid-stream with a full history, busy also asserted
        step(0, 1, 1, 1, 0, 0, 11, 1, 1, 0, 0);
        step(0, 1, 1, 1, 0, 0, 12, 1, 0, 0, 0);
        step(0, 1, 1, 1, 0, 0, 13, 1, 0, 0, 0);
        step(1, 1, 13, 1, 12, 1, 14, 1, 0, 1, 1);
        chk("in reset rs1_fwd", int'(rs1_fwd), 0);
        chk("in reset pipe_freeze", int'(pipe_freeze), 0);
        chk("in reset flush_if_id", int'(flush_if_id), 0);
        chk("in reset bubble_count", int'(bubble_count), 0);
        step(0, 1, 13, 1, 12, 1, 14, 1, 0, 0, 0);
        chk("post reset rs1_fwd", int'(rs1_fwd), 0);
        chk("post reset rs2_fwd", int'(rs2_fwd), 0);
        chk("post reset bubble_count", int'(bubble_count), 0);
        chk("post reset id_stall", int'(id_stall), 0);

        @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RISC-V core. It tracks the destination-register history of the three instructions ahead of decode (EX, MEM, WB) and produces the per-source forwarding selects for the decode-stage instruction. It also sequences load-use bubbles, branch-redirect flushes and memory-wait freezes. It sits between the decode stage and the EX/MEM/WB pipeline registers, replacing ad-hoc stall logic in the core top.

## Interface
- REG_AW, 5, register address width
- CNT_W, 16, width of the bubble performance counter
- clk  in  1  core clock
- reset  in  1  synchronous, active-high; one clock domain
- id_valid  in  1  decode holds a real instruction
- id_rs1_addr, id_rs2_addr  in  REG_AW  decode source addresses
- id_use_rs1, id_use_rs2  in  1  instruction reads that source
- id_rd_addr  in  REG_AW  decode destination
- id_rd_write  in  1  instruction writes rd
- id_is_load  in  1  rd value comes from data memory
- ex_redirect  in  1  branch/jump taken, resolved in EX this cycle
- mem_busy  in  1  data memory not ready; freeze the pipe
- rs1_fwd, rs2_fwd  out  2  0 = regfile, 1 = prev1 (EX), 2 = prev2 (MEM), 3 = prev3 (WB)
- rs1_take_mem, rs2_take_mem  out  1  the selected source is a load result (take the M path, not the EX path)
- id_stall  out  1  hold PC and IF/ID
- ex_bubble  out  1  load a NOP into ID/EX
- flush_if_id  out  1  squash IF/ID
- pipe_freeze  out  1  hold every pipeline register
- bubble_count  out  CNT_W  saturating count of inserted bubbles

## Operation
- History entries h1..h3 each hold {wr, rd, ld}. A write to rd == 0 is stored with wr = 0.
- Forwarding per source:
  - match_k = use && wr_k && rd_k == addr && addr != 0.
  - Priority is h1 > h2 > h3.
  - fwd = index of the highest-priority match, else 0.
  - take_mem = ld of the selected entry.
  - An unused source gives fwd = 0 and take_mem = 0.
- Load-use hazard: id_valid and a source matches h1 with ld_1 = 1. Result: id_stall = 1 and ex_bubble = 1 for exactly one advancing cycle.
- Redirect: ex_redirect = 1 gives flush_if_id = 1 and ex_bubble = 1, with id_stall = 0. Redirect overrides load-use, because the decode instruction is squashed.
- Freeze: mem_busy = 1 gives pipe_freeze = 1.
  - The history holds; id_stall, ex_bubble and flush_if_id are forced to 0.
  - Forwarding outputs stay valid, computed from the held state.
  - The redirect is re-evaluated when mem_busy drops, so the source stage must hold ex_redirect.
- Advance (mem_busy = 0):
  - h3 ← h2 and h2 ← h1.
  - h1 ← {id_rd_write & rd != 0, id_rd_addr, id_is_load} when id_valid and there is no bubble; otherwise h1 ← 0.
- bubble_count increments on each advancing cycle with ex_bubble = 1 and saturates at all-ones.

## Timing
- Forwarding, stall, flush and freeze outputs are combinational from the registered history and same-cycle inputs. There are zero cycles of latency.
- History and counter update on the rising clk edge.
- A load-use stall costs one cycle. The dependent instruction then sees the load in h2 and gets fwd = 2, take_mem = 1.
- Reset (synchronous, takes effect mid-operation):
  - h1..h3 and bubble_count clear to 0.
  - In the reset cycle all outputs are 0 and pipe_freeze = 0.
  - The first post-reset cycle sees an empty history.
- When reset and mem_busy are both asserted, reset wins.

## Structure
- Package pipeline_pkg holds:
  - hist_entry_t struct {wr, rd, ld}.
  - fwd_sel_t enum FWD_RF, FWD_P1, FWD_P2, FWD_P3.
  - Constant REG_AW.
- Sub-module fwd_select: per-source priority match, producing fwd, take_mem and load_use_hit. It is instantiated twice, once for rs1 and once for rs2.
- The top level holds the history shift register, bubble/flush arbitration and the counter.

## Test plan
- Load-use:
  - Stimulus: `lw x5`, then `add x6,x5,x1`.
  - Required response: cycle 2 has id_stall = 1 and ex_bubble = 1; cycle 3 has rs1_fwd = 2, rs1_take_mem = 1, id_stall = 0; bubble_count = 1.
- ALU chain:
  - Stimulus: `add x3`, `sub x3`, `or x7,x3,x3` back-to-back.
  - Required response: rs1_fwd = rs2_fwd = 1 (nearest writer), no stall.
- x0:
  - Stimulus: `addi x0,x0,1`, then `add x2,x0,x0`.
  - Required response: fwd = 0 on both sources, no stall.
- Redirect during load-use:
  - Stimulus: ex_redirect = 1 in the same cycle as a load-use match.
  - Required response: flush_if_id = 1, ex_bubble = 1, id_stall = 0; h1 is empty next cycle.
- mem_busy:
  - Stimulus: hold mem_busy for 3 cycles with x4 in h2.
  - Required response: pipe_freeze = 1, rs1_fwd stays 2, history unchanged; after release it shifts once per cycle.
- Reset mid-stream:
  - Stimulus: assert reset with a full history.
  - Required response: next cycle all outputs = 0, bubble_count = 0, forwarding to regfile.
